// File: rtl/axis_rx_if.sv
// -----------------------------------------------------------------------------
// axis_rx_if
// Receive-side AXI-Stream bundle coming out of the MAC. There is no ready
// signal: the consumer always accepts.
//   rdata  [63:0] beat data, payload byte 0 of the beat at [63:56]
//   ruser  [79:0] [79:64] payload length, [63:16] source MAC, [15:0] EtherType
//   rkeep  [7:0]  byte enables, rkeep[7] qualifies [63:56]
//   rlast         last beat of the frame
//   rvalid        beat valid
// Modports: master (MAC side, drives) / slave (checker side, observes).
// -----------------------------------------------------------------------------
interface axis_rx_if;
  logic [63:0] rdata;
  logic [79:0] ruser;
  logic [7:0]  rkeep;
  logic        rlast;
  logic        rvalid;

  modport master (output rdata, ruser, rkeep, rlast, rvalid);
  modport slave  (input  rdata, ruser, rkeep, rlast, rvalid);
endinterface

// File: rtl/axis_rx_check_module.sv
// -----------------------------------------------------------------------------
// axis_rx_check_module
// Checks each received frame against its user-field length, an optional
// incrementing byte pattern and an external CRC verdict, then accumulates
// saturating statistics.
//
// Optional feature: define RX_CHECK_PATTERN_EN to enable the payload pattern
// check (byte n of a frame must equal n[7:0], and rkeep must be contiguous).
// Without it o_pat_err_cnt is tied to zero.
//
// Ports:
//   i_clk, i_rst          single clock, synchronous active-high reset
//   s_axis                axis_rx_if.slave receive stream
//   i_crc_valid/_error    CRC verdict strobe for the most recent frame
//   o_frame_cnt .. o_pat_err_cnt   saturating frame/error counters
//   o_byte_cnt            total payload bytes, saturating
//   o_frame_done          one-cycle pulse when a frame is finalized
//   o_frame_pass          verdict of the last finalized frame
//   o_last_src_mac        source MAC of the last finalized frame
// -----------------------------------------------------------------------------
module axis_rx_check_module #(
  parameter int P_CRC_TIMEOUT = 16,
  parameter int P_CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  axis_rx_if.slave           s_axis,
  input  logic               i_crc_error,
  input  logic               i_crc_valid,
  output logic [P_CNT_W-1:0] o_frame_cnt,
  output logic [P_CNT_W-1:0] o_good_cnt,
  output logic [P_CNT_W-1:0] o_crc_err_cnt,
  output logic [P_CNT_W-1:0] o_len_err_cnt,
  output logic [P_CNT_W-1:0] o_pat_err_cnt,
  output logic [47:0]        o_byte_cnt,
  output logic               o_frame_done,
  output logic               o_frame_pass,
  output logic [47:0]        o_last_src_mac
);

  localparam int LP_TMR_W = $clog2(P_CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT_CRC} state_t;

  state_t              r_state;
  logic [31:0]         r_frame_bytes;
  logic                r_pat_err;
  logic [15:0]         r_len;
  logic [47:0]         r_mac;
  logic [LP_TMR_W-1:0] r_timer;

  // Finalization stage: the verdict cycle loads these, the next cycle counts.
  logic        r_fin_pend;
  logic [31:0] r_fin_bytes;
  logic        r_fin_crc_err;
  logic        r_fin_len_err;
  logic        r_fin_pat_err;
  logic [47:0] r_fin_mac;

  logic [3:0]  w_popcnt;
  logic        w_start;
  logic [31:0] w_base;
  logic [31:0] w_acc_bytes;
  logic        w_beat_pat_err;
  logic        w_acc_pat;
  logic [15:0] w_cur_len;
  logic [47:0] w_cur_mac;
  logic        w_timeout;
  logic        w_fin_good;
  logic [48:0] w_byte_sum;

  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] v);
    return (&v) ? v : v + P_CNT_W'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < 8; i++) w_popcnt = w_popcnt + {3'b000, s_axis.rkeep[i]};
  end

  // Any beat seen outside RECV is the first beat of a new frame.
  assign w_start     = (r_state != S_RECV);
  assign w_base      = w_start ? 32'd0 : r_frame_bytes;
  assign w_acc_bytes = w_base + {28'd0, w_popcnt};
  assign w_cur_len   = w_start ? s_axis.ruser[79:64] : r_len;
  assign w_cur_mac   = w_start ? s_axis.ruser[63:16] : r_mac;
  assign w_timeout   = (r_timer == LP_TMR_W'(P_CRC_TIMEOUT - 1));

`ifdef RX_CHECK_PATTERN_EN
  // Expected value of each enabled lane is the frame byte index; the index
  // advances only on enabled lanes so a sparse rkeep still counts set bits.
  always_comb begin
    logic [7:0] v_idx;
    w_beat_pat_err = (s_axis.rkeep != ~(8'hFF >> w_popcnt));
    v_idx          = w_base[7:0];
    for (int i = 0; i < 8; i++) begin
      if (s_axis.rkeep[7-i]) begin
        if (s_axis.rdata[63-8*i -: 8] != v_idx) w_beat_pat_err = 1'b1;
        v_idx = v_idx + 8'd1;
      end
    end
  end
`else
  assign w_beat_pat_err = 1'b0;
`endif

  assign w_acc_pat = (w_start ? 1'b0 : r_pat_err) | w_beat_pat_err;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_frame_bytes <= '0;
      r_pat_err     <= 1'b0;
      r_len         <= '0;
      r_mac         <= '0;
      r_timer       <= '0;
      r_fin_pend    <= 1'b0;
      r_fin_bytes   <= '0;
      r_fin_crc_err <= 1'b0;
      r_fin_len_err <= 1'b0;
      r_fin_pat_err <= 1'b0;
      r_fin_mac     <= '0;
    end else begin
      r_fin_pend <= 1'b0;

      // Beat accumulation is the same in every state.
      if (s_axis.rvalid) begin
        r_frame_bytes <= w_acc_bytes;
        r_pat_err     <= w_acc_pat;
        r_len         <= w_cur_len;
        r_mac         <= w_cur_mac;
        r_timer       <= '0;
      end

      case (r_state)
        S_IDLE, S_RECV: begin
          if (s_axis.rvalid) begin
            if (!s_axis.rlast) begin
              r_state <= S_RECV;
            end else if (i_crc_valid) begin
              r_fin_pend    <= 1'b1;
              r_fin_bytes   <= w_acc_bytes;
              r_fin_crc_err <= i_crc_error;
              r_fin_len_err <= (w_acc_bytes != {16'd0, w_cur_len});
              r_fin_pat_err <= w_acc_pat;
              r_fin_mac     <= w_cur_mac;
              r_state       <= S_IDLE;
            end else begin
              r_state <= S_WAIT_CRC;
            end
          end
        end

        S_WAIT_CRC: begin
          // A new beat or a timeout forces a CRC-error verdict; a verdict in
          // the same cycle as a new beat still belongs to the pending frame.
          if (i_crc_valid || s_axis.rvalid || w_timeout) begin
            r_fin_pend    <= 1'b1;
            r_fin_bytes   <= r_frame_bytes;
            r_fin_crc_err <= i_crc_valid ? i_crc_error : 1'b1;
            r_fin_len_err <= (r_frame_bytes != {16'd0, r_len});
            r_fin_pat_err <= r_pat_err;
            r_fin_mac     <= r_mac;
            if (!s_axis.rvalid)     r_state <= S_IDLE;
            else if (s_axis.rlast)  r_state <= S_WAIT_CRC;
            else                    r_state <= S_RECV;
          end else begin
            r_timer <= r_timer + LP_TMR_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fin_good = !(r_fin_crc_err || r_fin_len_err || r_fin_pat_err);
  assign w_byte_sum = {1'b0, o_byte_cnt} + {17'd0, r_fin_bytes};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_done   <= 1'b0;
      o_frame_pass   <= 1'b0;
      o_frame_cnt    <= '0;
      o_good_cnt     <= '0;
      o_crc_err_cnt  <= '0;
      o_len_err_cnt  <= '0;
`ifdef RX_CHECK_PATTERN_EN
      o_pat_err_cnt  <= '0;
`endif
      o_byte_cnt     <= '0;
      o_last_src_mac <= '0;
    end else begin
      o_frame_done <= r_fin_pend;
      if (r_fin_pend) begin
        o_frame_cnt <= sat_inc(o_frame_cnt);
        if (w_fin_good)    o_good_cnt    <= sat_inc(o_good_cnt);
        if (r_fin_crc_err) o_crc_err_cnt <= sat_inc(o_crc_err_cnt);
        if (r_fin_len_err) o_len_err_cnt <= sat_inc(o_len_err_cnt);
`ifdef RX_CHECK_PATTERN_EN
        if (r_fin_pat_err) o_pat_err_cnt <= sat_inc(o_pat_err_cnt);
`endif
        o_byte_cnt     <= w_byte_sum[48] ? '1 : w_byte_sum[47:0];
        o_last_src_mac <= r_fin_mac;
        o_frame_pass   <= w_fin_good;
      end
    end
  end

`ifndef RX_CHECK_PATTERN_EN
  assign o_pat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_rx_check_module.sv
// -----------------------------------------------------------------------------
// tb_axis_rx_check_module
// Directed frames are driven through axis_rx_if; each frame's expected
// verdict is queued when its last beat is sent and a monitor pops the queue
// on every o_frame_done, checking verdict, MAC, latency and all counters
// against a running model. A second instance with 2-bit counters sees the
// same traffic and must hold its counters saturated.
// -----------------------------------------------------------------------------
module tb_axis_rx_check_module;

  localparam int SAT_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  logic crc_valid, crc_error;
  always #5 clk = ~clk;

  axis_rx_if rx_if ();

  logic [31:0] frame_cnt, good_cnt, crc_err_cnt, len_err_cnt, pat_err_cnt;
  logic [47:0] byte_cnt, last_mac;
  logic        frame_done, frame_pass;

  logic [1:0]  s_frame_cnt, s_good_cnt, s_crc_err_cnt, s_len_err_cnt, s_pat_err_cnt;
  logic [47:0] s_byte_cnt, s_last_mac;
  logic        s_frame_done, s_frame_pass;

  axis_rx_check_module dut (
    .i_clk(clk), .i_rst(rst), .s_axis(rx_if),
    .i_crc_error(crc_error), .i_crc_valid(crc_valid),
    .o_frame_cnt(frame_cnt), .o_good_cnt(good_cnt), .o_crc_err_cnt(crc_err_cnt),
    .o_len_err_cnt(len_err_cnt), .o_pat_err_cnt(pat_err_cnt), .o_byte_cnt(byte_cnt),
    .o_frame_done(frame_done), .o_frame_pass(frame_pass), .o_last_src_mac(last_mac)
  );

  axis_rx_check_module #(.P_CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .s_axis(rx_if),
    .i_crc_error(crc_error), .i_crc_valid(crc_valid),
    .o_frame_cnt(s_frame_cnt), .o_good_cnt(s_good_cnt), .o_crc_err_cnt(s_crc_err_cnt),
    .o_len_err_cnt(s_len_err_cnt), .o_pat_err_cnt(s_pat_err_cnt), .o_byte_cnt(s_byte_cnt),
    .o_frame_done(s_frame_done), .o_frame_pass(s_frame_pass), .o_last_src_mac(s_last_mac)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          good, crc, len, pat;
    longint      bytes;
    logic [47:0] mac;
    int          t_last;
    int          lat;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_err = 0;
  longint m_frame, m_good, m_crc, m_len, m_pat, m_bytes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && frame_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        m_frame++;
        if (mon_e.good) m_good++;
        if (mon_e.crc)  m_crc++;
        if (mon_e.len)  m_len++;
        if (mon_e.pat)  m_pat++;
        m_bytes += mon_e.bytes;
        check("frame_pass",   frame_pass,  mon_e.good);
        check("last_src_mac", last_mac,    mon_e.mac);
        check("frame_cnt",    frame_cnt,   m_frame);
        check("good_cnt",     good_cnt,    m_good);
        check("crc_err_cnt",  crc_err_cnt, m_crc);
        check("len_err_cnt",  len_err_cnt, m_len);
        check("pat_err_cnt",  pat_err_cnt, m_pat);
        check("byte_cnt",     byte_cnt,    m_bytes);
        if (mon_e.lat >= 0) check("done_latency", cyc - mon_e.t_last, mon_e.lat);
        check("sat_done",      s_frame_done,  1);
        check("sat_frame_cnt", s_frame_cnt,   sat(m_frame));
        check("sat_good_cnt",  s_good_cnt,    sat(m_good));
        check("sat_crc_cnt",   s_crc_err_cnt, sat(m_crc));
        check("sat_len_cnt",   s_len_err_cnt, sat(m_len));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    @(posedge clk); #1;
    rx_if.rvalid = 1'b0;
    rx_if.rlast  = 1'b0;
    rx_if.rkeep  = 8'h00;
    crc_valid    = 1'b0;
    crc_error    = 1'b0;
  endtask

  // Called right after the last beat was driven; it lets that beat be sampled,
  // queues the expectation and drives the verdict d cycles after rlast
  // (d = 0: on the rlast cycle, d < 0: never).
  task automatic finish_frame(input int d, input logic cerr, input exp_t e, input bit lat_chk);
    drive_idle();
    e.t_last = cyc;
    e.crc    = (d < 0 || d > 16) ? 1'b1 : cerr;
    e.good   = !(e.crc || e.len || e.pat);
    e.lat    = !lat_chk ? -1 : ((d < 0 || d > 16) ? 17 : d + 1);
    sb_q.push_back(e);
    if (d > 0) begin
      repeat (d - 1) drive_idle();
      crc_valid = 1'b1;
      crc_error = cerr;
      drive_idle();
    end
  endtask

  task automatic send_frame(input int nbytes, input logic [15:0] len, input logic [47:0] mac,
                            input int bad_idx, input int d, input logic cerr,
                            input int gap_beat, input bit lat_chk);
    int   nb;
    int   idx;
    exp_t e;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_beat) begin
        // Mid-frame bubble carrying a stray CRC strobe that must be ignored.
        drive_idle();
        crc_valid = 1'b1;
        crc_error = 1'b1;
      end
      @(posedge clk); #1;
      rx_if.rkeep = 8'h00;
      for (int l = 0; l < 8; l++) begin
        idx = b * 8 + l;
        if (idx < nbytes) begin
          rx_if.rkeep[7-l]          = 1'b1;
          rx_if.rdata[63-8*l -: 8] = (idx == bad_idx) ? 8'hAA : 8'(idx);
        end else begin
          rx_if.rdata[63-8*l -: 8] = 8'h5A;
        end
      end
      rx_if.ruser  = (b == 0) ? {len, mac, 16'h0800} : {16'hFFFF, ~mac, 16'h0000};
      rx_if.rvalid = 1'b1;
      rx_if.rlast  = (b == nb - 1);
      crc_valid    = (b == nb - 1) && (d == 0);
      crc_error    = (b == nb - 1) && (d == 0) && cerr;
    end
    e.bytes = nbytes;
    e.mac   = mac;
    e.len   = (nbytes != int'(len));
`ifdef RX_CHECK_PATTERN_EN
    e.pat   = (bad_idx >= 0) && (bad_idx < nbytes);
`else
    e.pat   = 1'b0;
`endif
    finish_frame(d, cerr, e, lat_chk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("drain_within_bound", sb_q.size(), 0);
    drive_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exp_t e;
    rst          = 1'b1;
    rx_if.rvalid = 1'b0;
    rx_if.rlast  = 1'b0;
    rx_if.rkeep  = 8'h00;
    rx_if.rdata  = '0;
    rx_if.ruser  = '0;
    crc_valid    = 1'b0;
    crc_error    = 1'b0;
    {m_frame, m_good, m_crc, m_len, m_pat, m_bytes} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_frame_cnt", frame_cnt,   0);
    check("rst_good_cnt",  good_cnt,    0);
    check("rst_crc_cnt",   crc_err_cnt, 0);
    check("rst_len_cnt",   len_err_cnt, 0);
    check("rst_pat_cnt",   pat_err_cnt, 0);
    check("rst_byte_cnt",  byte_cnt,    0);
    check("rst_done",      frame_done,  0);
    check("rst_pass",      frame_pass,  0);
    check("rst_mac",       last_mac,    0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();

    // Good 64-byte frame, verdict two cycles after rlast.
    send_frame(64, 16'd64, 48'h0011_2233_4455, -1, 2, 1'b0, -1, 1'b1); drain();
    // 61 bytes against a declared length of 60.
    send_frame(61, 16'd60, 48'h0A0B_0C0D_0E0F, -1, 1, 1'b0, -1, 1'b1); drain();
    // Corrupted byte 10, verdict on the rlast cycle.
    send_frame(64, 16'd64, 48'h1111_2222_3333, 10, 0, 1'b0, -1, 1'b1); drain();
    // CRC error reported by the verdict strobe.
    send_frame(40, 16'd40, 48'h4444_5555_6666, -1, 3, 1'b1, -1, 1'b1); drain();
    // Verdict on the very last allowed cycle, with a stray-strobe bubble.
    send_frame(64, 16'd64, 48'h7777_8888_9999, -1, 16, 1'b0, 3, 1'b1); drain();
    // No verdict at all: timeout forces a CRC error.
    send_frame(32, 16'd32, 48'hAAAA_BBBB_CCCC, -1, -1, 1'b0, -1, 1'b1); drain();
    // Back-to-back: second frame arrives while the first awaits its verdict.
    send_frame(24, 16'd24, 48'hDDDD_EEEE_FFFF, -1, -1, 1'b0, -1, 1'b0);
    repeat (3) drive_idle();
    send_frame(16, 16'd16, 48'h1234_5678_9ABC, -1, 2, 1'b0, -1, 1'b1); drain();
    // Single-beat frames.
    send_frame(8, 16'd8, 48'h0000_0000_0001, -1, 0, 1'b0, -1, 1'b1); drain();
    send_frame(5, 16'd5, 48'h0000_0000_0002, -1, 1, 1'b0, -1, 1'b1); drain();

    // Non-contiguous rkeep: six set lanes carrying bytes 0..5 in order.
    @(posedge clk); #1;
    rx_if.rdata  = 64'h0001_02EE_0304_05EE;
    rx_if.rkeep  = 8'b1110_1110;
    rx_if.ruser  = {16'd6, 48'h0000_0000_0003, 16'h0800};
    rx_if.rvalid = 1'b1;
    rx_if.rlast  = 1'b1;
    e.bytes = 6;
    e.mac   = 48'h0000_0000_0003;
    e.len   = 1'b0;
`ifdef RX_CHECK_PATTERN_EN
    e.pat   = 1'b1;
`else
    e.pat   = 1'b0;
`endif
    finish_frame(1, 1'b0, e, 1'b1);
    drain();

    // The 2-bit instance has seen far more than three frames by now.
    @(negedge clk);
    check("sat_hold_frame_cnt", s_frame_cnt, 2'd3);
    check("sat_hold_byte_cnt",  s_byte_cnt,  m_bytes);

    // Reset after three beats of a frame: partial frame is discarded.
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      rx_if.rdata  = {8'(b*8), 8'(b*8+1), 8'(b*8+2), 8'(b*8+3),
                      8'(b*8+4), 8'(b*8+5), 8'(b*8+6), 8'(b*8+7)};
      rx_if.rkeep  = 8'hFF;
      rx_if.ruser  = {16'd64, 48'hBEEF_0000_0001, 16'h0800};
      rx_if.rvalid = 1'b1;
      rx_if.rlast  = 1'b0;
    end
    @(posedge clk); #1;
    rx_if.rvalid = 1'b0;
    rst          = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    {m_frame, m_good, m_crc, m_len, m_pat, m_bytes} = '0;
    @(negedge clk);
    check("mrst_frame_cnt", frame_cnt,   0);
    check("mrst_crc_cnt",   crc_err_cnt, 0);
    check("mrst_byte_cnt",  byte_cnt,    0);
    check("mrst_mac",       last_mac,    0);
    check("mrst_sat_cnt",   s_frame_cnt, 0);
    repeat (20) drive_idle();

    send_frame(64, 16'd64, 48'hCAFE_0000_0042, -1, 2, 1'b0, -1, 1'b1); drain();
    repeat (3) drive_idle();
    check("end_queue_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_rx_check_module.md
AXIS_RX_CHECK_MODULE -- requirements
Module: axis_rx_check_module

Interface
REQ-001 SHALL have parameter P_CRC_TIMEOUT, default 16: max cycles from rlast to crc_valid before verdict forced.
REQ-002 SHALL have parameter P_CNT_W, default 32: width of frame/error counters.
REQ-003 SHALL have port i_clk  in  1  XGMII-domain clock; single clock for whole block.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port s_axis_rdata  in  64  MAC RX data; byte 0 of beat at [63:56].
REQ-006 SHALL have port s_axis_ruser  in  80  [79:64] payload byte length, [63:16] source MAC, [15:0] EtherType; sampled on first beat.
REQ-007 SHALL have port s_axis_rkeep  in  8  byte enables, MSB-aligned contiguous; all ones except possibly on last beat.
REQ-008 SHALL have ports s_axis_rlast and s_axis_rvalid  in  1 each  frame end / beat valid; no ready, block always accepts.
REQ-009 SHALL have ports i_crc_error and i_crc_valid  in  1 each  CRC verdict strobe for the most recent frame.
REQ-010 SHALL have outputs o_frame_cnt, o_good_cnt, o_crc_err_cnt, o_len_err_cnt, o_pat_err_cnt  out  P_CNT_W each  saturating counters.
REQ-011 SHALL have output o_byte_cnt  out  48  total payload bytes received, saturating.
REQ-012 SHALL have outputs o_frame_done (1-cycle pulse), o_frame_pass  out  1 each  per-frame verdict.
REQ-013 SHALL have output o_last_src_mac  out  48  source MAC of last completed frame.

Function
REQ-014 SHALL implement FSM IDLE, RECV, WAIT_CRC.
REQ-015 IDLE: rvalid&!rlast -> RECV; rvalid&rlast (single-beat frame) -> WAIT_CRC; first beat latches ruser fields.
REQ-016 RECV: beats accepted only when rvalid=1; rvalid gaps mid-frame hold state; rvalid&rlast -> WAIT_CRC.
REQ-017 Byte count per frame SHALL add popcount(rkeep) per valid beat; non-contiguous rkeep counts set bits and flags pattern error.
REQ-018 Pattern: payload byte n of each frame SHALL equal n[7:0] (n from 0); each mismatched enabled byte flags the frame once.
REQ-019 i_crc_valid asserted on the rlast cycle or any WAIT_CRC cycle SHALL be taken as the frame's verdict.
REQ-020 No i_crc_valid within P_CRC_TIMEOUT cycles after rlast SHALL finalize the frame as CRC error.
REQ-021 rvalid in WAIT_CRC before verdict SHALL finalize pending frame as CRC error in that cycle and begin new frame from that beat.
REQ-022 Length error when frame byte count != ruser[79:64].
REQ-023 Finalization, 1 cycle after verdict: o_frame_done=1 for one cycle; o_frame_cnt+1; exactly one of o_good_cnt (no error of any kind) or the applicable error counters incremented (multiple error counters may increment together); o_byte_cnt += frame bytes; o_last_src_mac updated; FSM -> IDLE.
REQ-024 o_frame_pass SHALL equal good status of the last finalized frame, held until next o_frame_done.
REQ-025 All counters SHALL saturate at all ones, never wrap.
REQ-026 i_crc_valid in IDLE/RECV (stray) SHALL be ignored.

Reset
REQ-027 i_rst SHALL force FSM to IDLE and all outputs, counters, o_last_src_mac to 0 on next i_clk edge.
REQ-028 i_rst mid-frame SHALL discard the partial frame without counting; beats after reset release start a new frame only at an IDLE-accepted beat.

Configuration
REQ-029 Macro RX_CHECK_PATTERN_EN defined: REQ-018 pattern check active.
REQ-030 RX_CHECK_PATTERN_EN undefined: no pattern logic, o_pat_err_cnt tied 0, frames judged on CRC and length only; non-contiguous rkeep not flagged.

Verification
REQ-031 Single 64-byte frame, pattern 0..63, ruser len 64, crc_valid=1 crc_error=0 two cycles after rlast -> o_frame_done once, frame_cnt=1, good_cnt=1, byte_cnt=64, pass=1.
REQ-032 61-byte frame, last rkeep=8'b1111_1000, ruser len 60 -> len_err_cnt=1, good_cnt=0, byte_cnt=61, pass=0.
REQ-033 64-byte frame with byte 10 = 8'hAA, macro defined -> pat_err_cnt=1; macro undefined -> pat_err_cnt=0, good_cnt=1.
REQ-034 rlast with no crc_valid for 16 cycles -> crc_err_cnt=1 at cycle 17; back-to-back frame during WAIT_CRC -> first frame counted CRC error, second frame counted normally.
REQ-035 i_rst asserted after 3 beats of a frame -> all counters 0, no o_frame_done; following full frame counted good; preload counters near all ones -> saturation holds.
